inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Program-counter / instruction-fetch stage directly upstream of the instruction decoder.
- Holds the PC and presents the 9-bit instruction read from instruction ROM, qualified by a valid strobe.
- Resolves jz/jnz redirects returned by the decoder, using a 64-entry branch-target lookup table indexed by inst[5:0].
- Sequences program start, run and done for the top level.

Parameters:
- PC_W, 10, PC and branch-target width; ROM depth is 2^PC_W.
- LUT_DEPTH, 64, branch-target LUT entries; index width is log2(LUT_DEPTH) = 6, matching inst[5:0].
- CNT_W, 16, width of the cycle counter.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin execution; single-cycle pulse, level tolerated.
- StartAddr  in  PC_W  PC loaded when Start is accepted.
- EndAddr  in  PC_W  address of the last instruction of the program.
- InstIn  in  9  instruction-ROM data; combinational read at PC.
- jz  in  1  jump-if-zero from the decoder, for the current InstOut.
- jnz  in  1  jump-if-not-zero from the decoder, for the current InstOut.
- Zero  in  1  zero flag of the accumulator/ALU result.
- LutWe  in  1  branch-target LUT write enable.
- LutAddr  in  6  LUT write index.
- LutData  in  PC_W  LUT write data.
- PC  out  PC_W  current program counter, drives the ROM address.
- InstOut  out  9  instruction to the decoder, equal to InstIn.
- InstValid  out  1  high only in RUN; decoder side effects must be gated by it.
- Done  out  1  program finished.
- CycleCount  out  CNT_W  number of RUN cycles since the last accepted Start.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset is synchronous and active-high, and one clock is used.
- Reset, on the next edge:
  - state = IDLE, PC = 0, Done = 0, CycleCount = 0.
  - All LUT entries = 0.
  - InstValid = 0 (combinational from state).
- Reset has priority over every other input in the same cycle, including Start and LutWe.
- Reset mid-RUN: back to IDLE on the next edge; the in-flight instruction is not redirected.
- IDLE:
  - Start = 1 -> PC <= StartAddr, CycleCount <= 0, state <= RUN.
  - Otherwise hold.
- RUN:
  - InstValid = 1 and CycleCount increments every cycle, saturating at all-ones.
  - taken = jz ? Zero : (jnz ? ~Zero : 0). jz has priority if both are asserted; that case is illegal but defined.
  - If PC == EndAddr: state <= DONE and PC holds. A jump at EndAddr is ignored, so the instruction at EndAddr is the last one executed.
  - Else if taken: PC <= LUT[InstIn[5:0]].
  - Else: PC <= PC + 1, wrapping modulo 2^PC_W with no error.
  - Start is ignored.
- DONE:
  - Done = 1, InstValid = 0, PC and CycleCount hold.
  - Start = 1 -> Done <= 0, PC <= StartAddr, CycleCount <= 0, state <= RUN.
- Redirect latency: the target instruction is presented on the cycle after the jump instruction. There is no delay slot and no bubble.
- LUT:
  - Written synchronously in any state when LutWe = 1.
  - Read combinationally.
  - A same-cycle write and jump lookup of the same index uses the old entry; the new entry is visible next cycle.
- Zero is sampled in the same cycle as jz/jnz. This block does not register flags.
- StartAddr == EndAddr: exactly one RUN cycle, then DONE.

Test Plan:
- Reset, then Start with StartAddr = 0 and EndAddr = 3, no jumps -> PC sequence 0, 1, 2, 3. InstValid high for 4 cycles, Done = 1 in cycle 5, CycleCount = 4.
- Write LUT[5] = 0x040. In RUN at PC = 2, assert jz = 1 with Zero = 1 and InstIn[5:0] = 5 -> next PC = 0x040. Repeat with Zero = 0 -> next PC = 3.
- jnz = 1 with Zero = 0 and LUT[5] = 0x040 -> PC = 0x040. jnz = 1 with Zero = 1 -> PC + 1. jz = jnz = 1 with Zero = 0 -> PC + 1 (jz priority).
- PC = 0x3FF with EndAddr = 0x005, no jump -> PC wraps to 0x000. Assert Reset mid-RUN -> IDLE, PC = 0, Done = 0, all LUT entries read 0.
- Same-cycle LutWe to index 5 (new value 0x100) and jz-taken lookup of index 5 -> PC takes the old value. A second jump one cycle later -> 0x100.
- DONE then Start with StartAddr = 0x010 -> Done clears next edge, PC = 0x010, CycleCount restarts at 0. Start asserted during RUN -> no effect.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - program counter and instruction fetch stage with branch-target LUT
//
// Holds the PC that addresses instruction ROM, forwards the ROM word to the
// decoder qualified by InstValid, resolves jz/jnz redirects through a
// 64-entry branch-target table indexed by inst[5:0], and sequences
// IDLE -> RUN -> DONE for the top level.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous active-high reset (clears state, PC, counter, LUT)
//   Start       begin execution from StartAddr (accepted in IDLE and DONE)
//   StartAddr   PC loaded when Start is accepted
//   EndAddr     address of the last instruction of the program
//   InstIn      instruction ROM data read combinationally at PC
//   jz, jnz     decoder jump requests for the current InstOut
//   Zero        accumulator zero flag, sampled with jz/jnz
//   LutWe       branch-target LUT write enable
//   LutAddr     LUT write index
//   LutData     LUT write data
//   PC          current program counter / ROM address
//   InstOut     instruction to the decoder (pass-through of InstIn)
//   InstValid   high only while running
//   Done        program finished
//   CycleCount  RUN cycles since the last accepted Start (saturating)

module inst_fetch #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic [PC_W-1:0]  EndAddr,
    input  logic [8:0]       InstIn,
    input  logic             jz,
    input  logic             jnz,
    input  logic             Zero,
    input  logic             LutWe,
    input  logic [5:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  PC,
    output logic [8:0]       InstOut,
    output logic             InstValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic [PC_W-1:0] jump_target;
    logic            taken;

    // jz wins when both are asserted; the decoder should never do that.
    always_comb begin
        taken = 1'b0;
        if (jz) begin
            taken = Zero;
        end else if (jnz) begin
            taken = ~Zero;
        end
    end

    // Combinational read: a same-cycle write to this index lands on the
    // edge, so the lookup here still sees the old entry.
    assign jump_target = lut[InstIn[5:0]];

    assign InstOut   = InstIn;
    assign InstValid = (state == RUN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (LutWe) begin
            lut[LutAddr] <= LutData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= '0;
            Done       <= 1'b0;
            CycleCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        PC         <= StartAddr;
                        CycleCount <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (CycleCount != {CNT_W{1'b1}}) begin
                        CycleCount <= CycleCount + CNT_ONE;
                    end
                    // The end check comes first so a jump sitting at EndAddr
                    // cannot extend the program.
                    if (PC == EndAddr) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (taken) begin
                        PC <= jump_target;
                    end else begin
                        PC <= PC + PC_ONE;
                    end
                end
                DONE: begin
                    if (Start) begin
                        Done       <= 1'b0;
                        PC         <= StartAddr;
                        CycleCount <= '0;
                        state      <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
